// File: rtl/tt_pkg.sv
// Shared types and limits for the truth-table sequencer.
// FSM state encoding plus parameter ceilings.
package tt_pkg;

  localparam int N_IN_MAX   = 4;
  localparam int SETTLE_MAX = 15;
  localparam int TMR_W      = $clog2(SETTLE_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } tt_state_e;

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Bundle between the sequencer and its stimulus/DUT side.
// The sequencer takes the slave view.
interface truth_table_sequencer_if #(
  parameter int N_IN = 4
);

  logic                 start;
  logic [2**N_IN-1:0]   expected;
  logic                 dut_y;
  logic [N_IN-1:0]      vec;
  logic                 busy;
  logic                 done;
  logic [2**N_IN-1:0]   truth;
  logic                 pass;
  logic [N_IN:0]        err_count;
  logic [N_IN-1:0]      first_fail;

  modport master (
    output start,
    output expected,
    output dut_y,
    input  vec,
    input  busy,
    input  done,
    input  truth,
    input  pass,
    input  err_count,
    input  first_fail
  );

  modport slave (
    input  start,
    input  expected,
    input  dut_y,
    output vec,
    output busy,
    output done,
    output truth,
    output pass,
    output err_count,
    output first_fail
  );

endinterface

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that flags expiry at zero.
// Holds at zero until reloaded.
import tt_pkg::*;

module tt_settle_timer #(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps every input vector into a gate-level DUT,
// captures its truth table and scores it against a golden one.
import tt_pkg::*;

module truth_table_sequencer #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input logic                    clk,
  input logic                    reset,
  truth_table_sequencer_if.slave bus
);

  localparam int NV = 2**N_IN;
  localparam logic [N_IN-1:0] VEC_LAST = '1;
  localparam logic [N_IN:0] ERR_MAX = (N_IN+1)'(NV);
  localparam logic [TMR_W-1:0] LOAD_V = TMR_W'(SETTLE - 1);

  tt_state_e state_q, state_d;

  logic [NV-1:0]   exp_q, exp_d;
  logic [NV-1:0]   truth_q, truth_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [N_IN-1:0] ff_q, ff_d;
  logic [N_IN:0]   err_q, err_d;
  logic            pass_q, pass_d;

  logic tmr_load;
  logic tmr_en;
  logic tmr_exp;
  logic mismatch;

  tt_settle_timer #(
    .W (TMR_W)
  ) u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (LOAD_V),
    .en       (tmr_en),
    .expire   (tmr_exp)
  );

  assign mismatch = (bus.dut_y != exp_q[vec_q]);

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    truth_d  = truth_q;
    vec_d    = vec_q;
    ff_d     = ff_q;
    err_d    = err_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          exp_d    = bus.expected;
          truth_d  = '0;
          err_d    = '0;
          pass_d   = 1'b0;
          ff_d     = '0;
          vec_d    = '0;
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        tmr_en = 1'b1;
        if (tmr_exp) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        truth_d[vec_q] = bus.dut_y;
        if (mismatch) begin
          if (err_q == '0) begin
            ff_d = vec_q;
          end
          if (err_q != ERR_MAX) begin
            err_d = err_q + 1'b1;
          end
        end
        // Score on err_d so the last sample counts.
        if (vec_q == VEC_LAST) begin
          pass_d  = (err_d == '0);
          state_d = ST_DONE;
        end else begin
          vec_d    = vec_q + 1'b1;
          tmr_load = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      exp_q   <= '0;
      truth_q <= '0;
      vec_q   <= '0;
      ff_q    <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      truth_q <= truth_d;
      vec_q   <= vec_d;
      ff_q    <= ff_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.vec        = vec_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.truth      = truth_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = ff_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench: AND4, fault, all-wrong, start spam,
// mid-sweep reset on a 4-input unit; XOR3 on a 3-input unit.
module tb_truth_table_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   mode;
  int   dcyc;
  int   npul;
  int   waitc;

  always #5 clk = ~clk;

  truth_table_sequencer_if #(.N_IN(4)) a ();
  truth_table_sequencer_if #(.N_IN(3)) b ();

  truth_table_sequencer #(
    .N_IN   (4),
    .SETTLE (1)
  ) u_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a)
  );

  truth_table_sequencer #(
    .N_IN   (3),
    .SETTLE (2)
  ) u_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  // Gate-level DUT stand-ins.
  assign a.dut_y = (mode == 0) ? (&a.vec) :
                   (mode == 1) ? 1'b0 :
                   ~a.expected[a.vec];
  assign b.dut_y = ^b.vec;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic sweep_a(input bit spam,
                         output int dc,
                         output int np);
    a.start = 1'b1;
    tick();
    a.start = 1'b0;
    dc = 0;
    np = 0;
    for (int c = 1; c <= 40; c++) begin
      if (a.done) begin
        np++;
        if (dc == 0) dc = c;
      end
      if (spam) begin
        a.start = (c == 1 || c == 10 || c == 32);
        if (c == 5) a.expected = 16'hFFFF;
      end
      tick();
    end
    a.start = 1'b0;
  endtask

  task automatic sweep_b(output int dc,
                         output int np);
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
    dc = 0;
    np = 0;
    for (int c = 1; c <= 40; c++) begin
      if (b.done) begin
        np++;
        if (dc == 0) dc = c;
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    mode = 0;
    a.start = 1'b0;
    a.expected = 16'h8000;
    b.start = 1'b0;
    b.expected = 8'h96;
    tick();
    tick();
    reset = 1'b0;
    tick();

    chk("rst_vec", 32'(a.vec), 0);
    chk("rst_busy", 32'(a.busy), 0);
    chk("rst_done", 32'(a.done), 0);
    chk("rst_truth", 32'(a.truth), 0);
    chk("rst_pass", 32'(a.pass), 0);
    chk("rst_err", 32'(a.err_count), 0);
    chk("rst_ff", 32'(a.first_fail), 0);

    // AND4 clean sweep
    mode = 0;
    a.expected = 16'h8000;
    sweep_a(1'b0, dcyc, npul);
    chk("and4_cyc", 32'(dcyc), 33);
    chk("and4_pulses", 32'(npul), 1);
    chk("and4_truth", 32'(a.truth), 32'h8000);
    chk("and4_pass", 32'(a.pass), 1);
    chk("and4_err", 32'(a.err_count), 0);
    chk("and4_ff", 32'(a.first_fail), 0);
    chk("and4_vec", 32'(a.vec), 32'hF);
    chk("and4_busy", 32'(a.busy), 0);

    // output stuck at 0
    mode = 1;
    sweep_a(1'b0, dcyc, npul);
    chk("sa0_err", 32'(a.err_count), 1);
    chk("sa0_ff", 32'(a.first_fail), 32'hF);
    chk("sa0_pass", 32'(a.pass), 0);
    chk("sa0_truth", 32'(a.truth), 0);

    // every vector wrong
    mode = 2;
    a.expected = 16'hA5A5;
    sweep_a(1'b0, dcyc, npul);
    chk("allw_err", 32'(a.err_count), 16);
    chk("allw_ff", 32'(a.first_fail), 0);
    chk("allw_pass", 32'(a.pass), 0);
    chk("allw_truth", 32'(a.truth), 32'h5A5A);

    // start spam and expected churn mid-sweep
    mode = 0;
    a.expected = 16'h8000;
    sweep_a(1'b1, dcyc, npul);
    chk("spam_cyc", 32'(dcyc), 33);
    chk("spam_pulses", 32'(npul), 1);
    chk("spam_pass", 32'(a.pass), 1);
    chk("spam_truth", 32'(a.truth), 32'h8000);

    // reset while vec=5 settles
    a.expected = 16'h8000;
    a.start = 1'b1;
    tick();
    a.start = 1'b0;
    waitc = 0;
    while (a.vec != 4'd5 && waitc < 40) begin
      tick();
      waitc++;
    end
    chk("mid_reach5", 32'(a.vec), 5);
    chk("mid_busy", 32'(a.busy), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_vec", 32'(a.vec), 0);
    chk("mid_busy0", 32'(a.busy), 0);
    chk("mid_done", 32'(a.done), 0);
    chk("mid_truth", 32'(a.truth), 0);
    chk("mid_err", 32'(a.err_count), 0);
    chk("mid_pass", 32'(a.pass), 0);
    npul = 0;
    for (int c = 0; c < 40; c++) begin
      if (a.done) npul++;
      tick();
    end
    chk("mid_nodone", 32'(npul), 0);

    sweep_a(1'b0, dcyc, npul);
    chk("post_cyc", 32'(dcyc), 33);
    chk("post_pass", 32'(a.pass), 1);
    chk("post_truth", 32'(a.truth), 32'h8000);

    // XOR3, two settle cycles
    b.expected = 8'h96;
    sweep_b(dcyc, npul);
    chk("xor3_cyc", 32'(dcyc), 25);
    chk("xor3_pulses", 32'(npul), 1);
    chk("xor3_pass", 32'(b.pass), 1);
    chk("xor3_truth", 32'(b.truth), 32'h96);
    chk("xor3_err", 32'(b.err_count), 0);
    chk("xor3_vec", 32'(b.vec), 7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
